// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the execute stage: one-cycle registered multiply,
// 32-step restoring divide, HI/LO result held in DONE until the pipeline accepts it.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               msgn_q, msgn_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;

  logic [WIDTH:0]     rem_sh, diff;
  logic               no_borrow, dsgn;
  logic [WIDTH-1:0]   rem_nx, quot_nx;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return {WIDTH{1'b0}} - x;
  endfunction

  always_comb begin
    // Restoring step: rem needs one extra bit because the shifted value can exceed the divisor range
    rem_sh    = {rem_q, quot_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, dvsr_q};
    no_borrow = ~diff[WIDTH];
    rem_nx    = no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quot_nx   = {quot_q[WIDTH-2:0], no_borrow};

    ext_a = msgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b = msgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ext_a * ext_b;

    dsgn    = (op_i == 2'b10);
    state_d = state_q;
    cnt_d   = cnt_q;
    msgn_d  = msgn_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    unique case (state_q)
      S_IDLE: if (start_i && !flush_i) begin
        a_d    = a_i;
        b_d    = b_i;
        msgn_d = ~op_i[0];
        if (!op_i[1]) begin
          state_d = S_MUL;
        end else if (b_i == '0) begin
          hi_d    = a_i;
          lo_d    = '1;
          state_d = S_DONE;
        end else begin
          quot_d  = (dsgn && a_i[WIDTH-1]) ? neg(a_i) : a_i;
          dvsr_d  = (dsgn && b_i[WIDTH-1]) ? neg(b_i) : b_i;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = dsgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rneg_d  = dsgn && a_i[WIDTH-1];
          state_d = S_DIV;
        end
      end
      S_MUL: begin
        {hi_d, lo_d} = prod;
        state_d      = S_DONE;
      end
      S_DIV: begin
        rem_d  = rem_nx;
        quot_d = quot_nx;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          hi_d    = rneg_q ? neg(rem_nx) : rem_nx;
          lo_d    = qneg_q ? neg(quot_nx) : quot_nx;
          state_d = S_DONE;
        end
      end
      S_DONE: if (!hold_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A flushed instruction never reaches HI/LO
    if (flush_i) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      msgn_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msgn_q  <= msgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign stall_o        = (state_q == S_IDLE && start_i && !flush_i) ||
                          state_q == S_MUL || state_q == S_DIV;
  assign result_valid_o = (state_q == S_DONE) && !flush_i;
  assign busy_o         = (state_q != S_IDLE);
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;

endmodule
